// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//   Shared definitions for the rename register file: default widths, the
//   reserved zero register / zero tag / zero word constants, and a helper that
//   locates lane i inside a flattened multi-lane bus.
// -----------------------------------------------------------------------------
package rf_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_REG_W  = 5;
   localparam int RF_TAG_W  = 4;

   localparam logic [RF_REG_W-1:0]  ZERO_REG  = '0;  // x0, hard-wired zero
   localparam logic [RF_TAG_W-1:0]  ZERO_TAG  = '0;  // "no producer", value ready
   localparam logic [RF_DATA_W-1:0] ZERO_WORD = '0;

   // Lane i of a flattened bus occupies [lane_lsb(i, w) +: w].
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
//   One source-operand read lane. Resolves value/tag for register rs with the
//   priority: x0 -> in-bundle rename from an older dispatch lane -> commit
//   bypass -> stored entry.
// Ports
//   rs             source register index
//   ent_V, ent_Q   stored value and producer tag of register rs
//   alloc_*        this cycle's allocations on all dispatch lanes (only lanes
//                  below LANE_K are considered)
//   rollback_flag  suppresses in-bundle renaming
//   commit_*       this cycle's commits
//   V, Q           resolved value and tag
// -----------------------------------------------------------------------------
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int REG_W    = RF_REG_W,
   parameter int TAG_W    = RF_TAG_W,
   parameter int ISSUE_W  = 2,
   parameter int COMMIT_W = 2,
   parameter int LANE_K   = 0    // dispatch lane that owns this read port
) (
   input  logic [REG_W-1:0]           rs,
   input  logic [DATA_W-1:0]          ent_V,
   input  logic [TAG_W-1:0]           ent_Q,
   input  logic [ISSUE_W-1:0]         alloc_ena,
   input  logic [ISSUE_W*REG_W-1:0]   alloc_rd,
   input  logic [ISSUE_W*TAG_W-1:0]   alloc_Q,
   input  logic                       rollback_flag,
   input  logic [COMMIT_W-1:0]        commit_ena,
   input  logic [COMMIT_W*REG_W-1:0]  commit_rd,
   input  logic [COMMIT_W*TAG_W-1:0]  commit_Q,
   input  logic [COMMIT_W*DATA_W-1:0] commit_V,
   output logic [DATA_W-1:0]          V,
   output logic [TAG_W-1:0]           Q
);

   localparam logic [REG_W-1:0]  R0 = REG_W'(ZERO_REG);
   localparam logic [TAG_W-1:0]  T0 = TAG_W'(ZERO_TAG);
   localparam logic [DATA_W-1:0] W0 = DATA_W'(ZERO_WORD);

   logic              ren_hit;
   logic [TAG_W-1:0]  ren_Q;
   logic              byp_hit;
   logic [DATA_W-1:0] byp_V;

   // NOTE: every variable driven here gets a default on entry so that no path
   // leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      ren_hit = 1'b0;
      ren_Q   = T0;
      byp_hit = 1'b0;
      byp_V   = W0;

      // Ascending scan: a later (younger) hit overwrites an earlier one, so
      // the highest matching lane wins.
      for (int m = 0; m < ISSUE_W; m++) begin
         if (m < LANE_K && alloc_ena[m] &&
             alloc_rd[lane_lsb(m, REG_W) +: REG_W] == rs) begin
            ren_hit = 1'b1;
            ren_Q   = alloc_Q[lane_lsb(m, TAG_W) +: TAG_W];
         end
      end

      // A commit only forwards if it retires the producer the entry still
      // waits on; a stale commit must not mark the operand ready.
      for (int c = 0; c < COMMIT_W; c++) begin
         if (commit_ena[c] &&
             commit_rd[lane_lsb(c, REG_W) +: REG_W] == rs &&
             commit_Q[lane_lsb(c, TAG_W) +: TAG_W] == ent_Q) begin
            byp_hit = 1'b1;
            byp_V   = commit_V[lane_lsb(c, DATA_W) +: DATA_W];
         end
      end

      if (rs == R0) begin
         V = W0;
         Q = T0;
      end else if (ren_hit && !rollback_flag) begin
         V = W0;
         Q = ren_Q;
      end else if (byp_hit) begin
         V = byp_V;
         Q = T0;
      end else begin
         V = ent_V;
         Q = ent_Q;
      end
   end

endmodule

// File: rtl/rename_regfile_mp.sv
// -----------------------------------------------------------------------------
// rename_regfile_mp
//   Multi-lane architectural register file with rename tags. Each register
//   holds a value V and a producer tag Q (ROB id, 0 = ready).
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   rs_from_dsp     2*ISSUE_W source indices (read lanes 2k, 2k+1 -> dispatch k)
//   V_to_dsp        source values, combinational
//   Q_to_dsp        source tags, combinational
//   alloc_ena/rd/Q  per dispatch lane rd allocation with new producer tag
//   commit_ena/rd/Q/V  per commit lane retirement, lane 0 oldest
//   rollback_flag   clears every tag, drops this cycle's allocations
//   busy_mask       registered, bit r = (Q[r] != 0)
// -----------------------------------------------------------------------------
module rename_regfile_mp
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int REG_NUM  = 32,
   parameter int REG_W    = RF_REG_W,
   parameter int TAG_W    = RF_TAG_W,
   parameter int ISSUE_W  = 2,
   parameter int COMMIT_W = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2*ISSUE_W*REG_W-1:0]   rs_from_dsp,
   output logic [2*ISSUE_W*DATA_W-1:0]  V_to_dsp,
   output logic [2*ISSUE_W*TAG_W-1:0]   Q_to_dsp,
   input  logic [ISSUE_W-1:0]           alloc_ena,
   input  logic [ISSUE_W*REG_W-1:0]     alloc_rd,
   input  logic [ISSUE_W*TAG_W-1:0]     alloc_Q,
   input  logic [COMMIT_W-1:0]          commit_ena,
   input  logic [COMMIT_W*REG_W-1:0]    commit_rd,
   input  logic [COMMIT_W*TAG_W-1:0]    commit_Q,
   input  logic [COMMIT_W*DATA_W-1:0]   commit_V,
   input  logic                         rollback_flag,
   output logic [REG_NUM-1:0]           busy_mask
);

   localparam int READ_W = 2 * ISSUE_W;

   localparam logic [REG_W-1:0]  R0 = REG_W'(ZERO_REG);
   localparam logic [TAG_W-1:0]  T0 = TAG_W'(ZERO_TAG);
   localparam logic [DATA_W-1:0] W0 = DATA_W'(ZERO_WORD);

   logic [DATA_W-1:0] v_q   [REG_NUM];
   logic [TAG_W-1:0]  q_q   [REG_NUM];
   logic [DATA_W-1:0] v_nxt [REG_NUM];
   logic [TAG_W-1:0]  q_nxt [REG_NUM];
   logic [REG_NUM-1:0] clr;
   logic [REG_NUM-1:0] busy_nxt;

   // ---------------------------------------------------------------- reads
   for (genvar j = 0; j < READ_W; j++) begin : g_read
      logic [REG_W-1:0] rs_j;
      assign rs_j = rs_from_dsp[lane_lsb(j, REG_W) +: REG_W];

      rf_read_port #(
         .DATA_W   (DATA_W),
         .REG_W    (REG_W),
         .TAG_W    (TAG_W),
         .ISSUE_W  (ISSUE_W),
         .COMMIT_W (COMMIT_W),
         .LANE_K   (j / 2)
      ) u_read_port (
         .rs            (rs_j),
         .ent_V         (v_q[rs_j]),
         .ent_Q         (q_q[rs_j]),
         .alloc_ena     (alloc_ena),
         .alloc_rd      (alloc_rd),
         .alloc_Q       (alloc_Q),
         .rollback_flag (rollback_flag),
         .commit_ena    (commit_ena),
         .commit_rd     (commit_rd),
         .commit_Q      (commit_Q),
         .commit_V      (commit_V),
         .V             (V_to_dsp[lane_lsb(j, DATA_W) +: DATA_W]),
         .Q             (Q_to_dsp[lane_lsb(j, TAG_W) +: TAG_W])
      );
   end

   // ----------------------------------------------------------- next state
   // Order of the steps below encodes the precedence: commit writes V and
   // marks clears, then rollback or allocation overrides the tag.
   always_comb begin
      v_nxt = v_q;
      q_nxt = q_q;
      clr   = '0;

      for (int c = 0; c < COMMIT_W; c++) begin
         if (commit_ena[c] && commit_rd[lane_lsb(c, REG_W) +: REG_W] != R0) begin
            v_nxt[commit_rd[lane_lsb(c, REG_W) +: REG_W]] =
               commit_V[lane_lsb(c, DATA_W) +: DATA_W];
            // Compare against the pre-edge tag: a younger producer must keep
            // the register busy even if an older one retires now.
            if (q_q[commit_rd[lane_lsb(c, REG_W) +: REG_W]] ==
                commit_Q[lane_lsb(c, TAG_W) +: TAG_W])
               clr[commit_rd[lane_lsb(c, REG_W) +: REG_W]] = 1'b1;
         end
      end

      for (int r = 0; r < REG_NUM; r++)
         if (clr[r]) q_nxt[r] = T0;

      if (rollback_flag) begin
         for (int r = 0; r < REG_NUM; r++) q_nxt[r] = T0;
      end else begin
         for (int k = 0; k < ISSUE_W; k++)
            if (alloc_ena[k] && alloc_rd[lane_lsb(k, REG_W) +: REG_W] != R0)
               q_nxt[alloc_rd[lane_lsb(k, REG_W) +: REG_W]] =
                  alloc_Q[lane_lsb(k, TAG_W) +: TAG_W];
      end

      v_nxt[0] = W0;
      q_nxt[0] = T0;

      for (int r = 0; r < REG_NUM; r++)
         busy_nxt[r] = (q_nxt[r] != T0);
   end

   // -------------------------------------------------------------- storage
   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   // NOTE: the arrays are flop-based and reset element by element, because
   // the register file must read as all-zero immediately after reset; a RAM
   // macro could not provide that.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < REG_NUM; r++) begin
            v_q[r] <= W0;
            q_q[r] <= T0;
         end
         busy_mask <= '0;
      end else begin
         v_q       <= v_nxt;
         q_q       <= q_nxt;
         busy_mask <= busy_nxt;
      end
   end

   // Tag 0 means "ready", so allocating it would silently drop a dependency.
   for (genvar k = 0; k < ISSUE_W; k++) begin : g_alloc_chk
      a_alloc_tag_nonzero: assert property (@(posedge clk) disable iff (rst)
         alloc_ena[k] |-> (alloc_Q[lane_lsb(k, TAG_W) +: TAG_W] != T0));
   end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_rename_regfile_mp
//   Directed bench for rename_regfile_mp. Each step drives inputs on the
//   falling edge, queues the values it expects, and drains the queue either
//   1 ns later (combinational reads) or 1 ns after the rising edge
//   (registered state and busy_mask).
// -----------------------------------------------------------------------------
module tb_rename_regfile_mp;

   localparam int DATA_W   = 32;
   localparam int REG_NUM  = 32;
   localparam int REG_W    = 5;
   localparam int TAG_W    = 4;
   localparam int ISSUE_W  = 2;
   localparam int COMMIT_W = 2;
   localparam int RD_L     = 2 * ISSUE_W;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [2*ISSUE_W*REG_W-1:0]   rs_from_dsp;
   logic [2*ISSUE_W*DATA_W-1:0]  V_to_dsp;
   logic [2*ISSUE_W*TAG_W-1:0]   Q_to_dsp;
   logic [ISSUE_W-1:0]           alloc_ena;
   logic [ISSUE_W*REG_W-1:0]     alloc_rd;
   logic [ISSUE_W*TAG_W-1:0]     alloc_Q;
   logic [COMMIT_W-1:0]          commit_ena;
   logic [COMMIT_W*REG_W-1:0]    commit_rd;
   logic [COMMIT_W*TAG_W-1:0]    commit_Q;
   logic [COMMIT_W*DATA_W-1:0]   commit_V;
   logic                         rollback_flag;
   logic [REG_NUM-1:0]           busy_mask;

   rename_regfile_mp #(
      .DATA_W   (DATA_W),
      .REG_NUM  (REG_NUM),
      .REG_W    (REG_W),
      .TAG_W    (TAG_W),
      .ISSUE_W  (ISSUE_W),
      .COMMIT_W (COMMIT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rs_from_dsp   (rs_from_dsp),
      .V_to_dsp      (V_to_dsp),
      .Q_to_dsp      (Q_to_dsp),
      .alloc_ena     (alloc_ena),
      .alloc_rd      (alloc_rd),
      .alloc_Q       (alloc_Q),
      .commit_ena    (commit_ena),
      .commit_rd     (commit_rd),
      .commit_Q      (commit_Q),
      .commit_V      (commit_V),
      .rollback_flag (rollback_flag),
      .busy_mask     (busy_mask)
   );

   always #5 clk = ~clk;

   // Scoreboard entry: sel 0..RD_L-1 = V lane, RD_L..2*RD_L-1 = Q lane,
   // 2*RD_L = busy_mask.
   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   function automatic logic [63:0] observe(input int sel);
      if (sel < RD_L)
         return 64'(V_to_dsp[sel*DATA_W +: DATA_W]);
      else if (sel < 2*RD_L)
         return 64'(Q_to_dsp[(sel-RD_L)*TAG_W +: TAG_W]);
      else
         return 64'(busy_mask);
   endfunction

   task automatic exp_v(input string tag, input int j, input logic [DATA_W-1:0] v);
      sb.push_back('{tag: tag, sel: j, exp: 64'(v)});
   endtask

   task automatic exp_q(input string tag, input int j, input logic [TAG_W-1:0] q);
      sb.push_back('{tag: tag, sel: RD_L + j, exp: 64'(q)});
   endtask

   task automatic exp_busy(input string tag, input logic [REG_NUM-1:0] m);
      sb.push_back('{tag: tag, sel: 2*RD_L, exp: 64'(m)});
   endtask

   task automatic check();
      exp_t        e;
      logic [63:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         tests_run++;
         assert (obs === e.exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic idle();
      rs_from_dsp   = '0;
      alloc_ena     = '0;
      alloc_rd      = '0;
      alloc_Q       = '0;
      commit_ena    = '0;
      commit_rd     = '0;
      commit_Q      = '0;
      commit_V      = '0;
      rollback_flag = 1'b0;
   endtask

   task automatic set_rs(input int j, input logic [REG_W-1:0] r);
      rs_from_dsp[j*REG_W +: REG_W] = r;
   endtask

   task automatic set_alloc(input int k, input logic [REG_W-1:0] rd, input logic [TAG_W-1:0] q);
      alloc_ena[k]                = 1'b1;
      alloc_rd[k*REG_W +: REG_W]  = rd;
      alloc_Q[k*TAG_W +: TAG_W]   = q;
   endtask

   task automatic set_commit(input int c, input logic [REG_W-1:0] rd,
                             input logic [TAG_W-1:0] q, input logic [DATA_W-1:0] v);
      commit_ena[c]                 = 1'b1;
      commit_rd[c*REG_W +: REG_W]   = rd;
      commit_Q[c*TAG_W +: TAG_W]    = q;
      commit_V[c*DATA_W +: DATA_W]  = v;
   endtask

   task automatic drive_edge();
      @(negedge clk);
      idle();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- power-on reset
      rst = 1'b1;
      idle();
      #2;
      exp_busy("por_busy", '0);
      exp_q("por_q0", 0, '0);
      exp_v("por_v0", 0, '0);
      check();
      @(negedge clk);
      rst = 1'b0;

      // ---------------- T2 rename chain
      drive_edge();
      set_alloc(0, 5, 3);
      set_rs(0, 5);
      set_rs(2, 5);
      set_rs(3, 5);
      #1;
      exp_q("t2_own_lane_no_rename", 0, 0);
      exp_q("t2_rename_q_l2", 2, 3);
      exp_v("t2_rename_v_l2", 2, 0);
      exp_q("t2_rename_q_l3", 3, 3);
      check();
      tick();
      exp_busy("t2_busy", 32'h0000_0020);
      check();
      drive_edge();
      set_rs(0, 5);
      #1;
      exp_q("t2_next_q", 0, 3);
      check();

      // two lanes allocate the same rd: lane1 wins in storage
      drive_edge();
      set_alloc(0, 8, 1);
      set_alloc(1, 8, 2);
      set_rs(2, 8);
      #1;
      exp_q("dup_alloc_rename_l2", 2, 1);
      check();
      tick();
      exp_busy("dup_alloc_busy", 32'h0000_0120);
      check();
      drive_edge();
      set_rs(1, 8);
      #1;
      exp_q("dup_alloc_high_lane_wins", 1, 2);
      check();

      // ---------------- T3 commit bypass
      drive_edge();
      set_alloc(0, 7, 4);
      tick();
      exp_busy("t3_busy_alloc", 32'h0000_01A0);
      check();
      drive_edge();
      set_commit(0, 7, 4, 32'hDEAD);
      set_rs(0, 7);
      #1;
      exp_q("t3_bypass_q", 0, 0);
      exp_v("t3_bypass_v", 0, 32'hDEAD);
      check();
      tick();
      exp_busy("t3_busy_cleared", 32'h0000_0120);
      check();
      drive_edge();
      set_rs(0, 7);
      #1;
      exp_q("t3_next_q", 0, 0);
      exp_v("t3_next_v", 0, 32'hDEAD);
      check();

      // ---------------- T4 stale commit
      drive_edge();
      set_alloc(0, 7, 6);
      tick();
      drive_edge();
      set_commit(0, 7, 4, 32'h1);
      set_rs(0, 7);
      #1;
      exp_q("t4_no_bypass_q", 0, 6);
      exp_v("t4_no_bypass_v", 0, 32'hDEAD);
      check();
      tick();
      exp_busy("t4_busy_kept", 32'h0000_01A0);
      check();
      drive_edge();
      set_rs(0, 7);
      #1;
      exp_q("t4_q_kept", 0, 6);
      exp_v("t4_v_written", 0, 32'h1);
      check();

      // ---------------- T5 alloc vs commit, dual commit same rd
      drive_edge();
      set_alloc(0, 9, 2);
      tick();
      drive_edge();
      set_commit(0, 9, 2, 32'h99);
      set_alloc(1, 9, 5);
      tick();
      exp_busy("t5_alloc_beats_clear_busy", 32'h0000_03A0);
      check();
      drive_edge();
      set_rs(1, 9);
      #1;
      exp_q("t5_alloc_beats_clear_q", 1, 5);
      exp_v("t5_commit_v", 1, 32'h99);
      check();
      drive_edge();
      set_commit(0, 9, 5, 32'd10);
      set_commit(1, 9, 5, 32'd20);
      set_rs(3, 9);
      #1;
      exp_q("t5_dual_bypass_q", 3, 0);
      exp_v("t5_dual_bypass_v", 3, 32'd20);
      check();
      tick();
      exp_busy("t5_dual_busy", 32'h0000_01A0);
      check();
      drive_edge();
      set_rs(3, 9);
      #1;
      exp_q("t5_dual_q", 3, 0);
      exp_v("t5_high_lane_v", 3, 32'd20);
      check();

      // ---------------- T6 rollback
      drive_edge();
      set_alloc(0, 1, 1);
      set_alloc(1, 2, 2);
      tick();
      drive_edge();
      set_alloc(0, 3, 3);
      set_alloc(1, 4, 4);
      tick();
      exp_busy("t6_busy_pre", 32'h0000_01BE);
      check();
      drive_edge();
      rollback_flag = 1'b1;
      set_alloc(0, 1, 7);
      set_commit(0, 2, 9, 32'h55);
      set_commit(1, 0, 1, 32'h77);
      set_rs(1, 1);
      set_rs(2, 1);
      set_rs(3, 0);
      #1;
      exp_q("t6_entry_q", 1, 1);
      exp_q("t6_rename_suppressed", 2, 1);
      exp_q("t6_x0_q", 3, 0);
      exp_v("t6_x0_v", 3, 0);
      check();
      tick();
      exp_busy("t6_busy_flushed", '0);
      check();
      drive_edge();
      set_rs(0, 1);
      set_rs(1, 2);
      set_rs(2, 0);
      set_rs(3, 7);
      #1;
      exp_q("t6_alloc_dropped", 0, 0);
      exp_v("t6_commit_v", 1, 32'h55);
      exp_q("t6_commit_q", 1, 0);
      exp_v("t6_x0_v_after", 2, 0);
      exp_v("t6_v_untouched", 3, 32'h1);
      exp_q("t6_q_flushed", 3, 0);
      check();

      // writes to x0 are ignored
      drive_edge();
      set_alloc(0, 0, 5);
      set_commit(0, 0, 3, 32'h77);
      tick();
      exp_busy("x0_alloc_ignored", '0);
      check();

      // ---------------- T1 mid-run reset
      drive_edge();
      set_alloc(0, 10, 3);
      tick();
      exp_busy("t1_busy_pre", 32'h0000_0400);
      check();
      drive_edge();
      set_rs(0, 2);
      set_rs(1, 7);
      set_rs(2, 10);
      rst = 1'b1;
      #1;
      exp_v("t1_rst_v_l0", 0, 0);
      exp_v("t1_rst_v_l1", 1, 0);
      exp_q("t1_rst_q_l2", 2, 0);
      exp_busy("t1_rst_busy", '0);
      check();
      tick();
      exp_busy("t1_rst_busy_held", '0);
      check();
      drive_edge();
      rst = 1'b0;
      set_rs(0, 9);
      set_rs(2, 10);
      #1;
      exp_v("t1_post_v", 0, 0);
      exp_q("t1_post_q", 2, 0);
      check();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
